// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads one word per fetch from a synchronous RAM,
// and hands the captured instruction downstream over a valid/ready handshake.
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH = 28,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 'h100,
  parameter int                    PC_STRIDE  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_grant,
  input  logic                  halt,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [DATA_WIDTH-1:0] ir,
  output logic [ADDR_WIDTH-1:0] ir_pc,
  output logic                  ir_valid,
  input  logic                  ir_ready,
  output logic [ADDR_WIDTH-1:0] pc
);

  typedef enum logic [1:0] {
    S_REQ,
    S_DATA,
    S_HOLD
  } state_t;

  state_t state, state_next;
  logic   issue;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    if (redirect_valid) begin
      state_next = S_REQ;
    end else begin
      case (state)
        S_REQ: begin
          if (mem_grant && !halt) begin
            issue      = 1'b1;
            state_next = S_DATA;
          end
        end
        S_DATA:  state_next = S_HOLD;
        S_HOLD:  if (ir_valid && ir_ready) state_next = S_REQ;
        default: state_next = S_REQ;
      endcase
    end
  end

  // The RAM must see no select while reset is held, even though grant may be high.
  assign mem_cs   = issue && !rst;
  assign mem_oe   = issue && !rst;
  assign mem_we   = 1'b0;
  assign mem_addr = pc;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else begin
      state <= state_next;
      if (redirect_valid) begin
        // A redirect discards any in-flight capture and ignores ir_ready.
        pc       <= redirect_pc;
        ir_valid <= 1'b0;
      end else begin
        case (state)
          S_DATA: begin
            ir       <= mem_rdata;
            ir_pc    <= pc;
            pc       <= pc + ADDR_WIDTH'(PC_STRIDE);
            ir_valid <= 1'b1;
          end
          S_HOLD: begin
            if (ir_valid && ir_ready) ir_valid <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed scenarios push expected deliveries,
// a monitor pops and compares on every handshake.
module tb_instr_fetch_unit;

  typedef struct {
    logic [31:0] ir;
    logic [27:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [27:0] mem_addr, redirect_pc, ir_pc, pc;
  logic        mem_cs, mem_we, mem_oe, mem_grant, halt, redirect_valid, ir_valid, ir_ready;
  logic [31:0] mem_rdata, ir;

  logic [27:0] w_mem_addr, w_ir_pc, w_pc;
  logic        w_mem_cs, w_mem_we, w_mem_oe, w_grant, w_ir_valid, w_ready;
  logic [31:0] w_mem_rdata, w_ir;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   hs_count = 0;
  int   cyc      = 0;
  int   hs_cyc[$];
  exp_t sb[$];

  instr_fetch_unit u_dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_we(mem_we),
    .mem_oe(mem_oe), .mem_rdata(mem_rdata), .mem_grant(mem_grant), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .ir(ir), .ir_pc(ir_pc),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .pc(pc)
  );

  instr_fetch_unit #(.RESET_PC(28'hFFFFFFE)) u_wrap (
    .clk(clk), .rst(rst), .mem_addr(w_mem_addr), .mem_cs(w_mem_cs), .mem_we(w_mem_we),
    .mem_oe(w_mem_oe), .mem_rdata(w_mem_rdata), .mem_grant(w_grant), .halt(1'b0),
    .redirect_valid(1'b0), .redirect_pc(28'h0), .ir(w_ir), .ir_pc(w_ir_pc),
    .ir_valid(w_ir_valid), .ir_ready(w_ready), .pc(w_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_rd(input logic [27:0] a);
    case (a)
      28'h0000100: return 32'h1000011E;
      28'h0000102: return 32'h00000120;
      28'h0000104: return 32'h1800011C;
      28'h000011A: return 32'h7800000A;
      28'h0000200: return 32'h0000ABCD;
      28'hFFFFFFE: return 32'hAAAA0001;
      28'h0000000: return 32'h55550000;
      default:     return {4'hB, a};
    endcase
  endfunction

  // Synchronous-read RAM models: address sampled on the edge, data valid after it.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_cs && mem_oe && !mem_we) mem_rdata <= ram_rd(mem_addr);
    if (w_mem_cs && w_mem_oe && !w_mem_we) w_mem_rdata <= ram_rd(w_mem_addr);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples mid-cycle, where ir_valid/ir_ready are stable for the coming edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ir_valid && ir_ready && !redirect_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ir: got ir=0x%0h ir_pc=0x%0h, expected no delivery", ir, ir_pc);
      end else begin
        e = sb.pop_front();
        check("ir", {32'h0, ir}, {32'h0, e.ir});
        check("ir_pc", {36'h0, ir_pc}, {36'h0, e.pc});
      end
      hs_cyc.push_back(cyc);
      hs_count++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [27:0] a);
    exp_t e;
    e.ir = ram_rd(a);
    e.pc = a;
    sb.push_back(e);
  endtask

  task automatic wait_hs(input int target, input string name);
    int k = 0;
    while (hs_count < target && k < 40) begin
      step();
      k++;
    end
    check(name, 64'(hs_count >= target), 64'd1);
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!ir_valid && k < 40) begin
      step();
      k++;
    end
    check(name, {63'h0, ir_valid}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int k;
    rst = 1'b1; mem_grant = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    ir_ready = 1'b0; w_grant = 1'b0; w_ready = 1'b0;
    step(); step();

    // Reset state, with grant already high.
    check("rst_pc", {36'h0, pc}, 64'h100);
    check("rst_ir", {32'h0, ir}, 64'h0);
    check("rst_ir_pc", {36'h0, ir_pc}, 64'h0);
    check("rst_ir_valid", {63'h0, ir_valid}, 64'h0);
    check("rst_mem_cs", {63'h0, mem_cs}, 64'h0);
    check("rst_mem_oe", {63'h0, mem_oe}, 64'h0);
    check("rst_mem_we", {63'h0, mem_we}, 64'h0);

    // Sequential fetch.
    base = hs_count;
    push(28'h100); push(28'h102); push(28'h104);
    ir_ready = 1'b1;
    rst = 1'b0;
    #1;
    check("first_issue_cs", {63'h0, mem_cs}, 64'h1);
    check("first_issue_addr", {36'h0, mem_addr}, 64'h100);
    wait_hs(base + 3, "seq_timeout");
    mem_grant = 1'b0;
    check("seq_pc", {36'h0, pc}, 64'h106);
    if (hs_cyc.size() >= base + 3) begin
      check("seq_spacing1", 64'(hs_cyc[base+1] - hs_cyc[base]), 64'd3);
      check("seq_spacing2", 64'(hs_cyc[base+2] - hs_cyc[base+1]), 64'd3);
    end

    // Backpressure.
    rst = 1'b1; step();
    base = hs_count;
    ir_ready = 1'b0; mem_grant = 1'b1;
    push(28'h100); push(28'h102);
    rst = 1'b0;
    wait_valid("bp_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      check("bp_ir", {32'h0, ir}, 64'h1000011E);
      check("bp_ir_valid", {63'h0, ir_valid}, 64'h1);
      check("bp_no_cs", {63'h0, mem_cs}, 64'h0);
      step();
    end
    ir_ready = 1'b1;
    step();
    check("bp_issue_cs", {63'h0, mem_cs}, 64'h1);
    check("bp_issue_addr", {36'h0, mem_addr}, 64'h102);
    wait_hs(base + 2, "bp_timeout");
    mem_grant = 1'b0;

    // Redirect during DATA of 0x102.
    rst = 1'b1; step();
    base = hs_count;
    ir_ready = 1'b1; mem_grant = 1'b1;
    push(28'h100); push(28'h11A);
    rst = 1'b0;
    wait_hs(base + 1, "rd_first_timeout");
    check("rd_issue_addr", {36'h0, mem_addr}, 64'h102);
    step();
    redirect_valid = 1'b1; redirect_pc = 28'h11A;
    step();
    redirect_valid = 1'b0;
    check("rd_pc", {36'h0, pc}, 64'h11A);
    check("rd_ir_valid", {63'h0, ir_valid}, 64'h0);
    check("rd_ir_kept", {32'h0, ir}, 64'h1000011E);
    wait_hs(base + 2, "rd_timeout");
    mem_grant = 1'b0;
    check("rd_pc_after", {36'h0, pc}, 64'h11C);

    // Halt and grant.
    rst = 1'b1; step();
    base = hs_count;
    ir_ready = 1'b0; mem_grant = 1'b1;
    push(28'h100);
    rst = 1'b0;
    wait_valid("halt_valid_timeout");
    halt = 1'b1;
    step();
    ir_ready = 1'b1;
    step();
    check("halt_delivered", 64'(hs_count - base), 64'd1);
    for (int i = 0; i < 3; i++) begin
      check("halt_no_cs", {63'h0, mem_cs}, 64'h0);
      step();
    end
    redirect_valid = 1'b1; redirect_pc = 28'h200;
    step();
    redirect_valid = 1'b0;
    check("halt_rd_pc", {36'h0, pc}, 64'h200);
    check("halt_rd_idle", {63'h0, mem_cs}, 64'h0);
    halt = 1'b0; mem_grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("nogrant_no_cs", {63'h0, mem_cs}, 64'h0);
    end
    push(28'h200);
    mem_grant = 1'b1;
    #1;
    check("grant_issue_cs", {63'h0, mem_cs}, 64'h1);
    check("grant_issue_addr", {36'h0, mem_addr}, 64'h200);
    wait_hs(base + 2, "grant_timeout");
    mem_grant = 1'b0;

    // Wrap, on the instance reset to 0xFFFFFFE.
    rst = 1'b1; step();
    w_grant = 1'b1; w_ready = 1'b1;
    rst = 1'b0;
    #1;
    check("wrap_first_addr", {36'h0, w_mem_addr}, 64'hFFFFFFE);
    k = 0;
    while (!w_ir_valid && k < 40) begin step(); k++; end
    check("wrap_ir_pc", {36'h0, w_ir_pc}, 64'hFFFFFFE);
    check("wrap_ir", {32'h0, w_ir}, 64'hAAAA0001);
    check("wrap_pc", {36'h0, w_pc}, 64'h0);
    step();
    k = 0;
    while (!w_mem_cs && k < 40) begin step(); k++; end
    check("wrap_issue_addr", {36'h0, w_mem_addr}, 64'h0);
    k = 0;
    while (!w_ir_valid && k < 40) begin step(); k++; end
    check("wrap2_ir_pc", {36'h0, w_ir_pc}, 64'h0);
    check("wrap2_ir", {32'h0, w_ir}, 64'h55550000);
    w_grant = 1'b0;

    // Reset asserted mid-DATA.
    rst = 1'b1; step();
    base = hs_count;
    ir_ready = 1'b1; mem_grant = 1'b1;
    push(28'h100);
    rst = 1'b0;
    wait_hs(base + 1, "mr_first_timeout");
    step();
    #2;
    rst = 1'b1;
    #1;
    check("mr_ir_valid", {63'h0, ir_valid}, 64'h0);
    check("mr_mem_cs", {63'h0, mem_cs}, 64'h0);
    check("mr_mem_oe", {63'h0, mem_oe}, 64'h0);
    check("mr_pc", {36'h0, pc}, 64'h100);
    step();
    push(28'h100);
    rst = 1'b0;
    #1;
    check("mr_resume_addr", {36'h0, mem_addr}, 64'h100);
    wait_hs(base + 2, "mr_timeout");
    mem_grant = 1'b0;

    step(); step();
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Synthesizable instruction-fetch stage for the accumulator CPU. It sits between the program counter logic and the decode/execute stage. It owns the PC, issues read cycles to `single_port_sync_ram_large`, captures the returned word into an instruction register, and hands it downstream over a valid/ready handshake. Branch redirects, a halt level and a shared-memory grant from execute control when it fetches.

## Interface

Parameters:
- `ADDR_WIDTH`, default 28: width of the RAM address and of the PC.
- `DATA_WIDTH`, default 32: instruction and memory word width.
- `RESET_PC`, default 'h100: PC value loaded on reset.
- `PC_STRIDE`, default 2: PC increment per fetched instruction.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mem_addr` out ADDR_WIDTH: RAM address; equals `pc` in REQ, otherwise `pc` as well (don't-care to RAM).
- `mem_cs` out 1: RAM chip select.
- `mem_we` out 1: RAM write enable; constant 0.
- `mem_oe` out 1: RAM output enable, meaning the RAM drives the bus.
- `mem_rdata` in DATA_WIDTH: RAM read data.
- `mem_grant` in 1: execute stage allows fetch to use the RAM this cycle.
- `halt` in 1: level; while high, no new fetch is issued.
- `redirect_valid` in 1: load a new PC and flush.
- `redirect_pc` in ADDR_WIDTH: target PC.
- `ir` out DATA_WIDTH: fetched instruction.
- `ir_pc` out ADDR_WIDTH: address `ir` was fetched from.
- `ir_valid` out 1: `ir` holds an undelivered instruction.
- `ir_ready` in 1: downstream accepts `ir` this cycle.
- `pc` out ADDR_WIDTH: address of the next fetch.

## Operation

- There are three states: REQ, DATA and HOLD.
- **REQ**
  - Issues a fetch when `mem_grant && !halt`: `mem_cs`=1 and `mem_oe`=1 combinationally, with `mem_addr`=`pc`, and the next state is DATA.
  - Otherwise `mem_cs`=`mem_oe`=0 and the block stays in REQ.
- **DATA**
  - `mem_rdata` is valid because the RAM sampled the address at the previous edge.
  - On the edge: `ir`<=`mem_rdata`, `ir_pc`<=`pc`, `pc`<=`pc`+`PC_STRIDE`, `ir_valid`<=1, next state HOLD.
  - `mem_cs`=`mem_oe`=0 in DATA.
  - DATA always completes, regardless of `halt` or `mem_grant`.
- **HOLD**
  - `ir`, `ir_pc` and `ir_valid` are held stable while `ir_ready`=0.
  - When `ir_valid && ir_ready` is true on an edge: `ir_valid`<=0, next state REQ.
- **Redirect**
  - `redirect_valid`=1 has the highest priority in every state.
  - On the edge: `pc`<=`redirect_pc`, `ir_valid`<=0, next state REQ.
  - Any in-flight DATA capture is discarded: `ir` is unchanged and the PC is not incremented.
  - `ir_ready` in that same cycle is ignored.
- **Halt**
  - `halt` suppresses only new issues in REQ.
  - An instruction already in DATA or HOLD is still captured and delivered.
  - A redirect while halted updates `pc` and leaves the block in REQ, idle.
- **Arithmetic**
  - The PC is unsigned ADDR_WIDTH.
  - `pc`+`PC_STRIDE` wraps modulo 2^ADDR_WIDTH.
  - `redirect_pc` is taken verbatim; odd addresses are not checked.
- **Reset values**
  - `pc`=`RESET_PC`, `ir`=0, `ir_pc`=0, `ir_valid`=0, state=REQ.
  - `mem_cs`=`mem_oe`=`mem_we`=0 while `rst` is high.
  - Reset asserted mid-DATA or mid-HOLD abandons the fetch immediately.

## Timing

- **Fetch latency:** an issue at edge N in REQ gives capture at edge N+1, with `ir_valid` high after N+1.
- **Best-case throughput:** `ir_ready` tied high and `mem_grant` high gives one instruction per 3 cycles (REQ, DATA, HOLD).
- **Combinational paths:** `mem_cs` and `mem_oe` depend combinationally on `mem_grant` and `halt`. `mem_grant` must not depend combinationally on `mem_cs`.
- **Valid/ready rule:** `ir_valid` never drops without a handshake or a redirect. `ir` must not change while `ir_valid`=1 except by redirect (which clears valid).
- **First fetch after reset:** `rst` is released before edge E. The first issue happens in the REQ cycle ending at E, and `ir_valid` rises after E+1.

## Test plan

1. **Sequential fetch.**
   - Setup: RAM[0x100]=0x1000011E, RAM[0x102]=0x00000120, RAM[0x104]=0x1800011C; `ir_ready`=1, `mem_grant`=1.
   - Required: `ir` sequence 0x1000011E, 0x00000120, 0x1800011C, with `ir_pc` 0x100, 0x102, 0x104, spaced 3 cycles apart; `pc`=0x106 after the third capture.
2. **Backpressure.**
   - Stimulus: hold `ir_ready`=0 for 5 cycles after the first capture.
   - Required: `ir`=0x1000011E and `ir_valid`=1 stay stable; no `mem_cs` pulse; the fetch of 0x102 is issued the cycle after `ir_ready` rises.
3. **Redirect.**
   - Stimulus: assert `redirect_valid` with `redirect_pc`=0x11A during DATA of 0x102; RAM[0x11A]=0x7800000A.
   - Required: the 0x102 data is never presented; the next `ir` is 0x7800000A with `ir_pc`=0x11A; `pc` becomes 0x11C.
4. **Halt and grant.**
   - Stimulus: raise `halt` in HOLD.
   - Required: the current `ir` is still delivered, then `mem_cs` stays 0.
   - Stimulus: drop `halt` with `mem_grant`=0 for 4 cycles.
   - Required: no issue until `mem_grant`=1.
5. **Wrap.**
   - Setup: `RESET_PC`=0xFFFFFFE with `ADDR_WIDTH`=28.
   - Required: after one fetch `pc`=0x0000000, and the next fetch reads address 0.
6. **Reset mid-fetch.**
   - Stimulus: assert `rst` asynchronously during DATA.
   - Required: `ir_valid`, `mem_cs` and `mem_oe` are 0 immediately; `pc`=0x100; after release, fetching resumes at 0x100.
